// File: rtl/meikyuu_pkg.sv
// -----------------------------------------------------------------------------
// meikyuu_pkg
// Shared definitions for the push-button conditioning path:
//   - ch_state_t : per-button conditioning FSM states
//   - BTN_*      : bit positions of each button in key_n / press_pulse
//   - cnt_width  : width for the debounce and repeat counters of a channel
// -----------------------------------------------------------------------------
package meikyuu_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    HELD      = 3'd2,
    BLINK     = 3'd3,
    DEB_REL   = 3'd4
  } ch_state_t;

  localparam int unsigned NUM_BTNS  = 32'd4;
  localparam int unsigned BTN_UP    = 32'd3;
  localparam int unsigned BTN_DOWN  = 32'd2;
  localparam int unsigned BTN_LEFT  = 32'd1;
  localparam int unsigned BTN_RIGHT = 32'd0;

  // One spare bit above the largest timing parameter, so the counters
  // can always represent every compare value and still saturate cleanly.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    m = (b > m) ? b : m;
    m = (c > m) ? c : m;
    return int'($clog2(m)) + 32'd1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// Conditions one raw active-low button: two-flop synchronizer, debounce
// FSM with a stability counter, and an optional auto-repeat generator that
// inserts a single-cycle release "blink" while the button stays held.
// Ports:
//   clk      in  1  system clock, rising edge
//   reset    in  1  synchronous, active-low
//   key_n    in  1  raw asynchronous button, active-low
//   level_n  out 1  conditioned level, active-low, registered
//   press    out 1  one-cycle pulse per accepted press or repeat, registered
// -----------------------------------------------------------------------------
module debounce_channel
  import meikyuu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd250000,
  parameter int unsigned REPEAT_DELAY    = 32'd0,
  parameter int unsigned REPEAT_RATE     = 32'd3125000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level_n,
  output logic press
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] DELAY_LAST = (REPEAT_DELAY == 32'd0) ? CNT_ZERO
                                          : CNT_W'(REPEAT_DELAY - 32'd1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 32'd1);
  localparam logic             REPEAT_EN  = (REPEAT_DELAY != 32'd0);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             first_q, first_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] rpt_last;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // State register: every flop of the channel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      deb_cnt_q <= CNT_ZERO;
      rpt_cnt_q <= CNT_ZERO;
      first_q   <= 1'b0;
      level_q   <= 1'b1;
      pulse_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      rpt_cnt_q <= rpt_cnt_d;
      first_q   <= first_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
    end
  end

  // Synchronizer shift path.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
  end

  // The first repeat waits REPEAT_DELAY, later ones REPEAT_RATE.
  always_comb begin
    if (first_q) begin
      rpt_last = DELAY_LAST;
    end else begin
      rpt_last = RATE_LAST;
    end
  end

  // Next-state logic; sync2_q is the synchronized button.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!sync2_q) state_d = DEB_PRESS;
        else          state_d = IDLE;
      end
      DEB_PRESS: begin
        if (sync2_q)                     state_d = IDLE;
        else if (deb_cnt_q == DEB_LAST)  state_d = HELD;
        else                             state_d = DEB_PRESS;
      end
      HELD: begin
        if (sync2_q)                                  state_d = DEB_REL;
        else if (REPEAT_EN && (rpt_cnt_q == rpt_last)) state_d = BLINK;
        else                                          state_d = HELD;
      end
      BLINK: begin
        state_d = HELD;
      end
      DEB_REL: begin
        if (!sync2_q)                    state_d = HELD;
        else if (deb_cnt_q == DEB_LAST)  state_d = IDLE;
        else                             state_d = DEB_REL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Debounce / repeat counters and the first-repeat flag.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    rpt_cnt_d = rpt_cnt_q;
    first_d   = first_q;
    case (state_q)
      IDLE: begin
        deb_cnt_d = CNT_ZERO;
      end
      DEB_PRESS: begin
        if (sync2_q) begin
          deb_cnt_d = CNT_ZERO;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_cnt_d = CNT_ZERO;
          rpt_cnt_d = CNT_ZERO;
          first_d   = 1'b1;
        end else begin
          deb_cnt_d = sat_inc(deb_cnt_q);
        end
      end
      HELD: begin
        if (sync2_q) begin
          // Repeat count is kept so a release bounce does not restart it.
          deb_cnt_d = CNT_ZERO;
        end else if (REPEAT_EN && (rpt_cnt_q == rpt_last)) begin
          rpt_cnt_d = CNT_ZERO;
          first_d   = 1'b0;
        end else if (REPEAT_EN) begin
          rpt_cnt_d = sat_inc(rpt_cnt_q);
        end else begin
          rpt_cnt_d = rpt_cnt_q;
        end
      end
      BLINK: begin
        // The blink cycle itself counts toward the next repeat interval,
        // which makes blinks exactly REPEAT_RATE cycles apart.
        rpt_cnt_d = sat_inc(rpt_cnt_q);
      end
      DEB_REL: begin
        if (!sync2_q) begin
          deb_cnt_d = CNT_ZERO;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_cnt_d = CNT_ZERO;
        end else begin
          deb_cnt_d = sat_inc(deb_cnt_q);
        end
      end
      default: begin
        deb_cnt_d = CNT_ZERO;
        rpt_cnt_d = CNT_ZERO;
        first_d   = 1'b0;
      end
    endcase
  end

  // Output decode from the upcoming state so the outputs leave a flop.
  always_comb begin
    level_d = 1'b1;
    pulse_d = 1'b0;
    case (state_d)
      HELD, DEB_REL: level_d = 1'b0;
      default:       level_d = 1'b1;
    endcase
    if ((state_d == HELD) && ((state_q == DEB_PRESS) || (state_q == BLINK))) begin
      pulse_d = 1'b1;
    end else begin
      pulse_d = 1'b0;
    end
  end

  assign level_n = level_q;
  assign press   = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Four independent debounce/auto-repeat channels for the up/down/left/right
// buttons feeding the player movement stage.
// Ports:
//   CLOCK_25     in  1  25 MHz system clock
//   reset        in  1  synchronous, active-low
//   key_n        in  4  raw buttons, active-low ([3]=up [2]=down [1]=left [0]=right)
//   btn_up..btn_right out 1 each  conditioned levels, active-low
//   press_pulse  out 4  one-cycle press/repeat pulses, same bit order as key_n
// -----------------------------------------------------------------------------
module button_conditioner
  import meikyuu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd250000,
  parameter int unsigned REPEAT_DELAY    = 32'd0,
  parameter int unsigned REPEAT_RATE     = 32'd3125000
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic [3:0] key_n,
  output logic       btn_up,
  output logic       btn_down,
  output logic       btn_left,
  output logic       btn_right,
  output logic [3:0] press_pulse
);

  logic [NUM_BTNS-1:0] level_n;

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_ch (
      .clk     (CLOCK_25),
      .reset   (reset),
      .key_n   (key_n[gi]),
      .level_n (level_n[gi]),
      .press   (press_pulse[gi])
    );
  end

  assign btn_up    = level_n[BTN_UP];
  assign btn_down  = level_n[BTN_DOWN];
  assign btn_left  = level_n[BTN_LEFT];
  assign btn_right = level_n[BTN_RIGHT];

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Two DUT instances (auto-repeat on / off) share one stimulus stream. A
// reference model tracks each button as run lengths of stable synchronized
// samples plus elapsed hold time; its expected outputs are queued per clock
// and a monitor compares them against both DUTs on the falling edge.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_n;

  logic       up_a, down_a, left_a, right_a;
  logic [3:0] pp_a;
  logic       up_b, down_b, left_b, right_b;
  logic [3:0] pp_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_a (
    .CLOCK_25(clk), .reset(reset), .key_n(key_n),
    .btn_up(up_a), .btn_down(down_a), .btn_left(left_a), .btn_right(right_a),
    .press_pulse(pp_a)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_RATE(RR)) dut_b (
    .CLOCK_25(clk), .reset(reset), .key_n(key_n),
    .btn_up(up_b), .btn_down(down_b), .btn_left(left_b), .btn_right(right_b),
    .press_pulse(pp_b)
  );

  // ---------------- reference model ----------------
  bit m_s1 [2][4];
  bit m_s2 [2][4];
  bit m_pressed [2][4];
  bit m_blink [2][4];
  bit m_first [2][4];
  bit m_out [2][4];
  bit m_pulse [2][4];
  int m_run [2][4];    // consecutive samples opposing the current level
  int m_hold [2][4];   // cycles held since press or last blink

  logic [15:0] exp_q [$];

  task automatic model_step(input int u, input int rdelay);
    bit s;
    int target;
    for (int ch = 0; ch < 4; ch++) begin
      m_pulse[u][ch] = 1'b0;
      if (!reset) begin
        m_s1[u][ch] = 1'b1; m_s2[u][ch] = 1'b1;
        m_pressed[u][ch] = 1'b0; m_blink[u][ch] = 1'b0; m_first[u][ch] = 1'b0;
        m_out[u][ch] = 1'b1; m_run[u][ch] = 0; m_hold[u][ch] = 0;
      end else begin
        s = m_s2[u][ch];
        m_s2[u][ch] = m_s1[u][ch];
        m_s1[u][ch] = key_n[ch];
        if (m_blink[u][ch]) begin
          m_blink[u][ch] = 1'b0;
          m_out[u][ch] = 1'b0;
          m_pulse[u][ch] = 1'b1;
          m_hold[u][ch] = 1;
          m_run[u][ch] = 0;
        end else if (!m_pressed[u][ch]) begin
          if (s == 1'b0) begin
            m_run[u][ch]++;
            if (m_run[u][ch] == D + 1) begin
              m_pressed[u][ch] = 1'b1; m_run[u][ch] = 0;
              m_out[u][ch] = 1'b0; m_pulse[u][ch] = 1'b1;
              m_hold[u][ch] = 0; m_first[u][ch] = 1'b1;
            end
          end else begin
            m_run[u][ch] = 0;
          end
        end else begin
          if (s == 1'b1) begin
            m_run[u][ch]++;
            if (m_run[u][ch] == D + 1) begin
              m_pressed[u][ch] = 1'b0; m_run[u][ch] = 0; m_out[u][ch] = 1'b1;
            end
          end else if (m_run[u][ch] > 0) begin
            m_run[u][ch] = 0;   // release bounce: hold time resumes next cycle
          end else if (rdelay != 0) begin
            target = m_first[u][ch] ? rdelay : RR;
            if (m_hold[u][ch] == target - 1) begin
              m_blink[u][ch] = 1'b1; m_first[u][ch] = 1'b0; m_out[u][ch] = 1'b1;
            end else begin
              m_hold[u][ch]++;
            end
          end
        end
      end
    end
  endtask

  task automatic tick();
    logic [15:0] e;
    @(posedge clk);
    cyc++;
    model_step(0, RD);
    model_step(1, 0);
    for (int u = 0; u < 2; u++)
      for (int ch = 0; ch < 4; ch++) begin
        e[(1-u)*8 + 4 + ch] = m_out[u][ch];
        e[(1-u)*8 + ch]     = m_pulse[u][ch];
      end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  // ---------------- monitor / event log ----------------
  int          t0 = 0;
  int          log_max = 0;
  int          p_rel [$];
  logic [3:0]  p_vec [$];
  int          r_rel [$];
  logic [3:0]  r_mask [$];
  logic [3:0]  prev_btn = 4'b1111;

  always @(negedge clk) begin
    logic [15:0] e;
    logic [3:0]  cur;
    logic [3:0]  rise;
    int          rel;
    cur = {up_a, down_a, left_a, right_a};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({cur, pp_a} !== e[15:8]) begin
        bad++;
        $display("FAIL dut_a_outputs cyc=%0d: got btn=%b pulse=%b want btn=%b pulse=%b",
                 cyc, cur, pp_a, e[15:12], e[11:8]);
      end
      total++;
      if ({up_b, down_b, left_b, right_b, pp_b} !== e[7:0]) begin
        bad++;
        $display("FAIL dut_b_outputs cyc=%0d: got btn=%b pulse=%b want btn=%b pulse=%b",
                 cyc, {up_b, down_b, left_b, right_b}, pp_b, e[7:4], e[3:0]);
      end
    end
    rel  = cyc - t0;
    rise = cur & ~prev_btn;
    if (rel >= 1 && rel <= log_max) begin
      if (pp_a !== 4'b0000) begin
        p_rel.push_back(rel);
        p_vec.push_back(pp_a);
      end
      if (!$isunknown(rise) && rise != 4'b0000) begin
        r_rel.push_back(rel);
        r_mask.push_back(rise);
      end
    end
    prev_btn = cur;
  end

  task automatic open_log(input int window);
    log_max = 0;
    p_rel.delete(); p_vec.delete(); r_rel.delete(); r_mask.delete();
    t0 = cyc + 1;
    log_max = window;
  endtask

  function automatic int pev(input int i);
    return (i < p_rel.size()) ? (p_rel[i] * 16 + int'(p_vec[i])) : -1;
  endfunction

  function automatic int rev(input int i);
    return (i < r_rel.size()) ? (r_rel[i] * 16 + int'(r_mask[i])) : -1;
  endfunction

  // ---------------- stimulus ----------------
  int dur [4];
  int rp [4];
  int rr [3];

  initial begin
    rp = '{6, 17, 22, 27};
    rr = '{16, 21, 26};

    // Reset held with all keys pressed, then released for 5 cycles.
    reset = 1'b0; key_n = 4'b0000;
    open_log(8);
    ticks(3);
    reset = 1'b1;
    ticks(5);
    check("reset_no_pulse", p_rel.size(), 0);
    key_n = 4'b1111;
    ticks(20);

    // Clean press on up.
    key_n = 4'b0111;
    open_log(10);
    ticks(11);
    check("clean_press_count", p_rel.size(), 1);
    check("clean_press_pulse", pev(0), 6 * 16 + 8);
    key_n = 4'b1111;
    ticks(12);

    // Bounce on left, never stable long enough.
    open_log(20);
    key_n = 4'b1101; ticks(3);
    key_n = 4'b1111; ticks(1);
    key_n = 4'b1101; ticks(3);
    key_n = 4'b1111; ticks(14);
    check("bounce_no_pulse", p_rel.size(), 0);
    check("bounce_no_rise", r_rel.size(), 0);

    // Right pressed, then release with bounce.
    key_n = 4'b1110; ticks(12);
    key_n = 4'b1111; ticks(2);
    key_n = 4'b1110; ticks(1);
    key_n = 4'b1111;
    open_log(10);
    ticks(11);
    check("release_rise", rev(0), 6 * 16 + 1);
    check("release_no_pulse", p_rel.size(), 0);
    ticks(5);

    // Auto-repeat on down.
    key_n = 4'b1011;
    open_log(40);
    ticks(40);
    key_n = 4'b1111;
    ticks(1);
    for (int i = 0; i < 4; i++) check($sformatf("repeat_pulse%0d", i), pev(i), rp[i] * 16 + 4);
    for (int i = 0; i < 3; i++) check($sformatf("repeat_blink%0d", i), rev(i), rr[i] * 16 + 4);
    ticks(15);

    // Mid-hold reset (both instances; dut_b has repeat disabled).
    key_n = 4'b0111; ticks(12);
    reset = 1'b0; ticks(1);
    reset = 1'b1; ticks(12);
    key_n = 4'b1111; ticks(12);

    // Randomized bouncing and holds with occasional resets.
    for (int ch = 0; ch < 4; ch++) dur[ch] = $urandom_range(1, 20);
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (dur[ch] == 0) begin
          key_n[ch] = ~key_n[ch];
          dur[ch] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
        end else begin
          dur[ch]--;
        end
      end
      reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    reset = 1'b1;
    key_n = 4'b1111;
    ticks(20);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
